// File: rtl/traffic_light_controller_if.sv
// rtl/traffic_light_controller_if.sv - sensor inputs and light/timer outputs of the intersection sequencer
interface traffic_light_controller_if #(
    parameter int TW = 4
);
    logic          car;
    logic          preempt;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          state_changed;

    modport master (
        output car,
        output preempt,
        input  state,
        input  timer,
        input  state_changed
    );

    modport slave (
        input  car,
        input  preempt,
        output state,
        output timer,
        output state_changed
    );
endinterface

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - highway/country-road light sequencer with tick-based phase timer
module traffic_light_controller #(
    parameter int TICK_DIV    = 4,
    parameter int LONG_TICKS  = 5,
    parameter int SHORT_TICKS = 2,
    parameter int TW          = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    traffic_light_controller_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        HG = 2'b00,
        HY = 2'b01,
        SG = 2'b11,
        SY = 2'b10
    } light_t;

    light_t        state_q;
    light_t        state_d;
    logic [PW-1:0] prescaler;
    logic [TW-1:0] timer_q;
    logic          changed_q;
    logic          car_meta;
    logic          car_s;
    logic          preempt_meta;
    logic          preempt_s;
    logic          tick;
    logic          long_to;
    logic          short_to;

    assign tick     = (prescaler == PW'(TICK_DIV - 1));
    assign long_to  = (timer_q >= TW'(LONG_TICKS));
    assign short_to = (timer_q >= TW'(SHORT_TICKS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: if (car_s && long_to && !preempt_s) state_d = HY;
            HY: if (short_to) state_d = preempt_s ? HG : SG;
            // Country green has no minimum dwell: it yields as soon as the road empties.
            SG: if (!car_s || long_to || preempt_s) state_d = SY;
            SY: if (short_to) state_d = HG;
            default: state_d = HG;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HG;
            timer_q      <= '0;
            prescaler    <= '0;
            changed_q    <= 1'b0;
            car_meta     <= 1'b0;
            car_s        <= 1'b0;
            preempt_meta <= 1'b0;
            preempt_s    <= 1'b0;
        end else begin
            car_meta     <= bus.car;
            car_s        <= car_meta;
            preempt_meta <= bus.preempt;
            preempt_s    <= preempt_meta;
            state_q      <= state_d;
            changed_q    <= (state_d != state_q);
            if (state_d != state_q) begin
                timer_q   <= '0;
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick && !long_to)
                    timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign bus.state         = state_q;
    assign bus.timer         = timer_q;
    assign bus.state_changed = changed_q;
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - randomized bench against a phase/elapsed-cycle reference model
module tb_traffic_light_controller;
    localparam int TICK_DIV    = 4;
    localparam int LONG_TICKS  = 5;
    localparam int SHORT_TICKS = 2;
    localparam int TW          = 4;
    localparam logic [1:0] ENC [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    traffic_light_controller_if #(.TW(TW)) bus_if ();

    traffic_light_controller #(
        .TICK_DIV   (TICK_DIV),
        .LONG_TICKS (LONG_TICKS),
        .SHORT_TICKS(SHORT_TICKS),
        .TW         (TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase index 0..3 (HG,HY,SG,SY), edges elapsed since phase entry,
    // and the raw input history the synchronizer delays by two edges.
    int   m_phase;
    int   m_cnt;
    int   m_sc;
    logic car_hist[$];
    logic pre_hist[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_sc    = 0;
        car_hist = '{1'b0, 1'b0};
        pre_hist = '{1'b0, 1'b0};
    endtask

    function automatic int model_timer();
        int t;
        t = m_cnt / TICK_DIV;
        return (t > LONG_TICKS) ? LONG_TICKS : t;
    endfunction

    task automatic model_edge(input logic c, input logic p);
        logic car_s, pre_s, tl, ts;
        int   nxt;
        car_s = car_hist[car_hist.size() - 2];
        pre_s = pre_hist[pre_hist.size() - 2];
        tl    = (model_timer() >= LONG_TICKS);
        ts    = (model_timer() >= SHORT_TICKS);
        nxt   = m_phase;
        case (m_phase)
            0: if (car_s && tl && !pre_s) nxt = 1;
            1: if (ts) nxt = pre_s ? 0 : 2;
            2: if (!car_s || tl || pre_s) nxt = 3;
            default: if (ts) nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_cnt   = 0;
            m_sc    = 1;
        end else begin
            if (m_cnt < 1000) m_cnt++;
            m_sc = 0;
        end
        car_hist.push_back(c);
        pre_hist.push_back(p);
        if (car_hist.size() > 4) void'(car_hist.pop_front());
        if (pre_hist.size() > 4) void'(pre_hist.pop_front());
    endtask

    task automatic compare_outputs();
        check_eq("state", int'(bus_if.state), int'(ENC[m_phase]));
        check_eq("timer", int'(bus_if.timer), model_timer());
        check_eq("state_changed", int'(bus_if.state_changed), m_sc);
    endtask

    // Called at a negedge: compare, drive new inputs, advance one edge, return at next negedge.
    task automatic cycle(input logic c, input logic p);
        compare_outputs();
        bus_if.car     = c;
        bus_if.preempt = p;
        @(posedge clk);
        model_edge(c, p);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_state", int'(bus_if.state), 0);
        check_eq("rst_timer", int'(bus_if.timer), 0);
        check_eq("rst_pulse", int'(bus_if.state_changed), 0);
        model_reset();
        @(negedge clk);
        compare_outputs();
        reset = 1'b0;
    endtask

    initial begin
        int   pulses;
        int   edges;
        int   nd;
        int   dwell [4];
        int   seq [4];
        logic [1:0] prev;
        logic c, p;
        int   guard;

        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus_if.car     = 1'b0;
        bus_if.preempt = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs();
        reset = 1'b0;

        // Idle highway: stays green, timer saturates, no pulses.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0);
            if (bus_if.state_changed) pulses++;
        end
        check_eq("idle_state", int'(bus_if.state), 0);
        check_eq("idle_timer_sat", int'(bus_if.timer), LONG_TICKS);
        check_eq("idle_pulses", pulses, 0);

        // Car held from reset: measure the four phase dwells.
        @(negedge clk);
        async_reset();
        edges = 0;
        nd    = 0;
        prev  = bus_if.state;
        for (int i = 0; i < 4; i++) begin
            dwell[i] = 0;
            seq[i]   = 0;
        end
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, 1'b0);
            edges++;
            if (bus_if.state != prev) begin
                if (nd < 4) begin
                    dwell[nd] = edges;
                    seq[nd]   = int'(bus_if.state);
                    nd++;
                end
                edges = 0;
                prev  = bus_if.state;
            end
        end
        check_eq("dwell_hg", dwell[0], 21);
        check_eq("dwell_hy", dwell[1], 9);
        check_eq("dwell_sg", dwell[2], 21);
        check_eq("dwell_sy", dwell[3], 9);
        check_eq("seq_hy", seq[0], 1);
        check_eq("seq_sg", seq[1], 3);
        check_eq("seq_sy", seq[2], 2);
        check_eq("seq_hg", seq[3], 0);

        // Run into SY, then reset asynchronously between edges.
        guard = 0;
        while (bus_if.state != 2'b10 && guard < 200) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check_eq("reach_sy", int'(bus_if.state), 2);
        cycle(1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);

        // Randomized car/preempt traffic with occasional async resets.
        c = 1'b0;
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) c = ~c;
            if ($urandom_range(0, 59) == 0) p = ~p;
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle(c, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
